// File: rtl/sram_controller_if.sv
// sram_controller_if: MEM-stage load/store handshake between pipeline and SRAM controller.
interface sram_controller_if;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  modport master (output wr_en, rd_en, address, write_data, input read_data, ready);
  modport slave  (input wr_en, rd_en, address, write_data, output read_data, ready);
endinterface

// File: rtl/sram_controller.sv
// sram_controller: splits a 32-bit MEM-stage load/store into two 16-bit SRAM accesses, low half first.
// Optional SRAM_ADDR_CHECK_EN: out-of-window addresses skip the bus and complete in one cycle.
module sram_controller #(
  parameter int          ACCESS_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR     = 32'd1024
) (
  input  logic                clk,
  input  logic                rst,
  sram_controller_if.slave    bus,
  inout  wire  [15:0]         SRAM_DQ,
  output logic [17:0]         SRAM_ADDR,
  output logic                SRAM_WE_N
);
  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;
  localparam logic [3:0] LAST = 4'(ACCESS_CYCLES - 1);
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic [17:0] addr_q, addr_d;
  logic        wr_q, wr_d, rd_q, rd_d;
  logic [16:0] word;
  logic        req, last, ok, drive;
  always_comb begin
    word = 17'((bus.address - BASE_ADDR) >> 2);
    req  = bus.rd_en | bus.wr_en;
    last = cnt_q == LAST;
`ifdef SRAM_ADDR_CHECK_EN
    ok = ({1'b0, bus.address} >= {1'b0, BASE_ADDR}) &&
         ({1'b0, bus.address} <  {1'b0, BASE_ADDR} + 33'h8_0000);
`else
    ok = 1'b1;
`endif
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    case (state_q)
      IDLE: if (req) begin
        wr_d    = bus.wr_en;
        rd_d    = bus.rd_en & ~bus.wr_en;
        cnt_d   = '0;
        state_d = ok ? LOW : DONE;
        addr_d  = ok ? {word, 1'b0} : addr_q;
        // rejected loads return zero without touching the bus
        rdata_d = (!ok && rd_d) ? 32'h0 : rdata_q;
      end
      LOW: begin
        cnt_d = last ? 4'd0 : cnt_q + 4'd1;
        if (last) begin
          state_d = HIGH;
          addr_d  = {addr_q[17:1], 1'b1};
          if (rd_q) rdata_d[15:0] = SRAM_DQ;
        end
      end
      HIGH: begin
        cnt_d = last ? 4'd0 : cnt_q + 4'd1;
        if (last) begin
          state_d = DONE;
          if (rd_q) rdata_d[31:16] = SRAM_DQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
    end
  end
  // bus drive decodes straight from state so reset releases it at once
  assign drive         = wr_q && (state_q == LOW || state_q == HIGH);
  assign SRAM_DQ       = drive ? (state_q == HIGH ? bus.write_data[31:16] : bus.write_data[15:0]) : 16'bz;
  assign SRAM_WE_N     = ~drive;
  assign SRAM_ADDR     = addr_q;
  assign bus.read_data = rdata_q;
  assign bus.ready     = ~(req && state_q != DONE);
endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: randomized loads/stores against a word-level memory model of the SRAM window.
module tb_sram_controller;
  localparam int A = 2;
`ifdef SRAM_ADDR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  wire  [15:0] SRAM_DQ;
  logic [17:0] SRAM_ADDR;
  logic        SRAM_WE_N;
  logic [15:0] mem [0:262143];
  logic [31:0] refm [int];
  logic [31:0] exp_rd = 32'h0;
  int          n_cmp = 0;
  int          n_bad = 0;
  sram_controller_if bus();
  sram_controller #(.ACCESS_CYCLES(A), .BASE_ADDR(32'd1024)) dut (
    .clk(clk), .rst(rst), .bus(bus), .SRAM_DQ(SRAM_DQ), .SRAM_ADDR(SRAM_ADDR), .SRAM_WE_N(SRAM_WE_N)
  );
  always #5 clk = ~clk;
  assign SRAM_DQ = SRAM_WE_N ? mem[SRAM_ADDR] : 16'bz;
  always @(posedge clk) if (!SRAM_WE_N) mem[SRAM_ADDR] <= SRAM_DQ;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [16:0] word_of(input logic [31:0] a);
    return 17'((a - 32'd1024) >> 2);
  endfunction
  function automatic bit in_window(input logic [31:0] a);
    return !CHK || (64'(a) >= 64'd1024 && 64'(a) < 64'd1024 + 64'd524288);
  endfunction
  task automatic op(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d, input bit gap);
    int stall, we_lo, bad_bus;
    logic [16:0] wd;
    bit full;
    wd = word_of(a);
    full = in_window(a);
    @(negedge clk);
    bus.wr_en = w; bus.rd_en = r; bus.address = a; bus.write_data = d;
    #1;
    stall = 0; we_lo = 0; bad_bus = 0;
    while (bus.ready == 1'b0 && stall < 40) begin
      stall++;
      if (!SRAM_WE_N) begin
        if (SRAM_ADDR !== {wd, we_lo >= A}) bad_bus++;
        if (SRAM_DQ !== (we_lo < A ? d[15:0] : d[31:16])) bad_bus++;
        we_lo++;
      end
      @(negedge clk); #1;
    end
    check("stall_cycles", stall, full ? 2 * A + 1 : 1);
    check("we_cycles", we_lo, (w && full) ? 2 * A : 0);
    check("bus_addr_data", bad_bus, 0);
    if (w && full) refm[int'(wd)] = d;
    else if (r && !w) exp_rd = !full ? 32'h0 : (refm.exists(int'(wd)) ? refm[int'(wd)] : 32'h0);
    check("read_data", bus.read_data, exp_rd);
    if (gap) begin
      bus.wr_en = 1'b0; bus.rd_en = 1'b0;
      @(negedge clk); #1;
      check("idle_ready", bus.ready, 1'b1);
    end
  endtask
  initial begin
    for (int i = 0; i < 262144; i++) mem[i] = 16'h0;
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.address = 32'h0; bus.write_data = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_read_data", bus.read_data, 32'h0);
    check("rst_sram_addr", SRAM_ADDR, 32'h0);
    check("rst_we_n", SRAM_WE_N, 1'b1);
    rst = 1'b1;
    @(negedge clk); #1;
    check("rst_ready", bus.ready, 1'b1);
    op(1'b1, 1'b0, 32'd1028, 32'hDEAD_BEEF, 1'b1);
    op(1'b0, 1'b1, 32'd1028, 32'h0, 1'b1);
    op(1'b1, 1'b0, 32'd1024, 32'hCAFE_F00D, 1'b0);
    op(1'b0, 1'b1, 32'd1032, 32'h0, 1'b0);
    op(1'b0, 1'b1, 32'd1024, 32'h0, 1'b1);
    op(1'b1, 1'b1, 32'd1024, 32'h1234_5678, 1'b1);
    op(1'b0, 1'b1, 32'd1024, 32'h0, 1'b1);
    op(1'b0, 1'b1, 32'd512, 32'h0, 1'b1);
    op(1'b1, 1'b0, 32'd512, 32'h5555_AAAA, 1'b1);
    op(1'b0, 1'b1, 32'd512, 32'h0, 1'b1);
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      int k;
      k = $urandom_range(0, 9);
      a = (k == 0) ? 32'd1024 + 32'd524288 + 4 * $urandom_range(0, 3) :
          (k == 1) ? 32'd1020 : 32'd1024 + 4 * $urandom_range(0, 31) + $urandom_range(0, 3);
      k = $urandom_range(0, 6);
      op(k < 3, k >= 2, a, $urandom, $urandom_range(0, 1) == 1);
    end
    op(1'b0, 1'b1, 32'd1028, 32'h0, 1'b1);
    @(negedge clk);
    bus.wr_en = 1'b1; bus.rd_en = 1'b0; bus.address = 32'd1036; bus.write_data = 32'hA5A5_5A5A;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_we_n", SRAM_WE_N, 1'b1);
    check("abort_read_data", bus.read_data, 32'h0);
    bus.wr_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    check("post_rst_ready", bus.ready, 1'b1);
    exp_rd = 32'h0;
    refm.delete(int'(word_of(32'd1036)));
    op(1'b1, 1'b0, 32'd1036, 32'h0BAD_F00D, 1'b1);
    op(1'b0, 1'b1, 32'd1036, 32'h0, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
